// File: rtl/byte_logic_pkg.sv
// Shared constants for the byte logic arbiter: opcode encodings and FSM states.
package byte_logic_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
    localparam logic [OP_W-1:0] OP_AND  = 3'b001;
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/byte_logic_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, modulo NREQ.
module rr_arbiter
    import byte_logic_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            any_grant
);

    int unsigned idx;

    // Walk the ring starting at rr_ptr; rr_ptr is always kept below NREQ.
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = IDW'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_logic_arbiter.sv
// Round-robin shared byte logic unit: accept one request, execute in a registered
// stage, return the result on a single tagged response channel.
module byte_logic_arbiter
    import byte_logic_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [OP_W*NREQ-1:0]     req_op,
    input  logic [DATA_W*NREQ-1:0]   req_a,
    input  logic [DATA_W*NREQ-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_zero,
    output logic                     busy
);

    state_t              state, state_nxt;
    logic [IDW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [OP_W-1:0]     op_q, op_nxt;
    logic [DATA_W-1:0]   a_q, a_nxt;
    logic [DATA_W-1:0]   b_q, b_nxt;
    logic [IDW-1:0]      id_q, id_nxt;
    logic                rsp_valid_nxt;
    logic [DATA_W-1:0]   rsp_data_nxt;
    logic [IDW-1:0]      rsp_id_nxt;
    logic                rsp_zero_nxt;

    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      winner;
    logic                any_grant;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [DATA_W-1:0]   result;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[OP_W*i +: OP_W];
                sel_a  = req_a[DATA_W*i +: DATA_W];
                sel_b  = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    // Shared logic unit, evaluated from the captured operands only.
    always_comb begin
        result = '0;
        case (op_q)
            OP_NOT:  result = ~a_q;
            OP_AND:  result = a_q & b_q;
            OP_OR:   result = a_q | b_q;
            OP_NAND: result = ~(a_q & b_q);
            OP_NOR:  result = ~(a_q | b_q);
            OP_XOR:  result = a_q ^ b_q;
            OP_XNOR: result = ~(a_q ^ b_q);
            OP_PASS: result = a_q;
            default: result = '0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        op_nxt        = op_q;
        a_nxt         = a_q;
        b_nxt         = b_q;
        id_nxt        = id_q;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_id_nxt    = rsp_id;
        rsp_zero_nxt  = rsp_zero;
        req_ready     = '0;
        case (state)
            ST_IDLE: begin
                if (any_grant) begin
                    req_ready  = grant;
                    op_nxt     = sel_op;
                    a_nxt      = sel_a;
                    b_nxt      = sel_b;
                    id_nxt     = winner;
                    rr_ptr_nxt = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_nxt  = result;
                rsp_zero_nxt  = (result == '0);
                rsp_id_nxt    = id_q;
                rsp_valid_nxt = 1'b1;
                state_nxt     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_nxt = 1'b0;
                state_nxt     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_zero  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            op_q      <= op_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            id_q      <= id_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_id    <= rsp_id_nxt;
            rsp_zero  <= rsp_zero_nxt;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_byte_logic_arbiter.sv
// Self-checking bench for byte_logic_arbiter: directed tables, corner sequences and
// a randomized run against a cycle-level reference model.
module tb_byte_logic_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [3*NREQ-1:0]   req_op;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [7:0]          rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_zero;
    logic                busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    byte_logic_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic drive(input int i, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        req_valid[i]     = v;
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{3'd0, 8'hCC, 8'hAA, 8'h33};
        vecs[1] = '{3'd1, 8'hCC, 8'hAA, 8'h88};
        vecs[2] = '{3'd2, 8'hCC, 8'hAA, 8'hEE};
        vecs[3] = '{3'd3, 8'hCC, 8'hAA, 8'h77};
        vecs[4] = '{3'd4, 8'hCC, 8'hAA, 8'h11};
        vecs[5] = '{3'd5, 8'hCC, 8'hAA, 8'h66};
        vecs[6] = '{3'd6, 8'hCC, 8'hAA, 8'h99};
        vecs[7] = '{3'd7, 8'hCC, 8'hAA, 8'hCC};
        vecs[8] = '{3'd1, 8'h0F, 8'hF0, 8'h00};
        vecs[9] = '{3'd6, 8'h3C, 8'hC3, 8'h00};

        // Reset state
        do_reset();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_zero", rsp_zero, 0);

        // Single request and latency
        drive(0, 1'b1, 3'd0, 8'h5A, 8'h00);
        #1 chk("single_ready", req_ready, 3'b001);
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("single_exec_busy", busy, 1);
        chk("single_exec_valid", rsp_valid, 0);
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_data", rsp_data, 8'hA5);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_rsp_zero", rsp_zero, 0);
        @(negedge clk);
        chk("single_done_valid", rsp_valid, 0);
        chk("single_done_busy", busy, 0);

        // Opcode sweep from the vector table
        for (int v = 0; v < 10; v++) begin
            drive(0, 1'b1, vecs[v].op, vecs[v].a, vecs[v].b);
            #1 chk("sweep_ready", req_ready, 3'b001);
            @(negedge clk);
            drive(0, 1'b0, 3'd0, 8'hFF, 8'hFF);
            @(negedge clk);
            chk("sweep_data", rsp_data, vecs[v].exp);
            chk("sweep_zero", rsp_zero, (vecs[v].exp == 8'h00) ? 1 : 0);
            chk("sweep_id", rsp_id, 0);
            @(negedge clk);
            chk("sweep_done", rsp_valid, 0);
        end

        // Contention between requesters 0 and 1
        do_reset();
        drive(0, 1'b1, 3'd5, 8'hF0, 8'h0F);
        drive(1, 1'b1, 3'd5, 8'hFF, 8'hFF);
        #1 chk("cont_first_grant", req_ready, 3'b001);
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("cont_exec_ready", req_ready, 0);
        @(negedge clk);
        chk("cont_rsp0_data", rsp_data, 8'hFF);
        chk("cont_rsp0_id", rsp_id, 0);
        chk("cont_rsp0_zero", rsp_zero, 0);
        chk("cont_resp_ready", req_ready, 0);
        @(negedge clk);
        chk("cont_second_grant", req_ready, 3'b010);
        @(negedge clk);
        drive(1, 1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("cont_rsp1_data", rsp_data, 8'h00);
        chk("cont_rsp1_id", rsp_id, 1);
        chk("cont_rsp1_zero", rsp_zero, 1);
        @(negedge clk);
        chk("cont_done", rsp_valid, 0);

        // Backpressure hold in RESP
        rsp_ready = 1'b0;
        drive(0, 1'b1, 3'd2, 8'h12, 8'h34);
        #1 chk("bp_grant", req_ready, 3'b001);
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 8'h00, 8'h00);
        drive(1, 1'b1, 3'd1, 8'h3C, 8'h0F);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 8'h36);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", req_ready, 3'b010);
        @(negedge clk);
        drive(1, 1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("bp_rsp1_data", rsp_data, 8'h0C);
        chk("bp_rsp1_id", rsp_id, 1);
        @(negedge clk);

        // Fairness and pointer wrap with all three requesting
        do_reset();
        for (int i = 0; i < 3; i++) drive(i, 1'b1, 3'd7, 8'(i + 1), 8'h00);
        for (int k = 0; k < 6; k++) begin
            #1 chk("fair_grant", req_ready, 32'(1) << (k % 3));
            @(negedge clk);
            @(negedge clk);
            chk("fair_rsp_id", rsp_id, k % 3);
            chk("fair_rsp_data", rsp_data, (k % 3) + 1);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 3'd0, 8'h00, 8'h00);

        // Reset asserted while in EXEC
        drive(2, 1'b1, 3'd0, 8'h00, 8'h00);
        #1 chk("mid_grant", req_ready, 3'b100);
        @(negedge clk);
        drive(2, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("mid_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("mid_no_stale", rsp_valid, 0);
            @(negedge clk);
        end
        drive(0, 1'b1, 3'd7, 8'h42, 8'h00);
        drive(2, 1'b1, 3'd7, 8'h24, 8'h00);
        #1 chk("mid_first_grant", req_ready, 3'b001);
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 8'h00, 8'h00);
        drive(2, 1'b0, 3'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("mid_rsp_id", rsp_id, 0);
        chk("mid_rsp_data", rsp_data, 8'h42);
        @(negedge clk);

        // Randomized traffic against a cycle-level reference model
        do_reset();
        begin
            int              mstate;   // 0 idle, 1 executing, 2 responding
            int              mptr;
            int              w;
            logic [7:0]      mres;
            int              mid;
            logic [NREQ-1:0] accepted;
            logic [NREQ-1:0] exp_ready;
            mstate   = 0;
            mptr     = 0;
            mres     = '0;
            mid      = 0;
            accepted = '0;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (accepted[i] || !req_valid[i]) begin
                        if ($urandom_range(0, 2) == 0)
                            drive(i, 1'b1, 3'($urandom), 8'($urandom), 8'($urandom));
                        else
                            drive(i, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
                    end else if ($urandom_range(0, 15) == 0) begin
                        drive(i, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
                    end
                end
                rsp_ready = ($urandom_range(0, 3) != 0);
                #1;
                w = -1;
                exp_ready = '0;
                if (mstate == 0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        int i;
                        i = (mptr + k) % NREQ;
                        if (w < 0 && req_valid[i]) w = i;
                    end
                    if (w >= 0) exp_ready[w] = 1'b1;
                end
                chk("rnd_ready", req_ready, exp_ready);
                chk("rnd_valid", rsp_valid, (mstate == 2) ? 1 : 0);
                chk("rnd_busy", busy, (mstate != 0) ? 1 : 0);
                if (mstate == 2) begin
                    chk("rnd_data", rsp_data, mres);
                    chk("rnd_id", rsp_id, mid);
                    chk("rnd_zero", rsp_zero, (mres == 8'h00) ? 1 : 0);
                end
                accepted = '0;
                case (mstate)
                    0: if (w >= 0) begin
                        mres        = ref_op(req_op[3*w +: 3], req_a[8*w +: 8], req_b[8*w +: 8]);
                        mid         = w;
                        mptr        = (w + 1) % NREQ;
                        accepted[w] = 1'b1;
                        mstate      = 1;
                    end
                    1: mstate = 2;
                    default: if (rsp_ready) mstate = 0;
                endcase
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
